// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: CPU data-side memory controller.
// Word-array global and stack regions answer in one cycle; a wait-state
// peripheral window is reached through a held p_req/p_ack handshake with a
// timeout. Byte/half/word accesses, alignment checking and a sticky fault
// capture register that remembers the first faulting address.
module data_mem_ctrl #(
   parameter logic [31:0] GLOBAL_BASE  = 32'h1001_0000,
   parameter int          GLOBAL_WORDS = 32,
   parameter logic [31:0] STACK_TOP    = 32'h7FFF_FFFC,
   parameter int          STACK_WORDS  = 32,
   parameter logic [31:0] PERI_BASE    = 32'h4000_0000,
   parameter logic [31:0] PERI_SPAN    = 32'h0000_1000,
   parameter int          PERI_TIMEOUT = 16,
   parameter logic [31:0] ERR_DATA     = 32'hCCCC_CCCC
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        unsgn,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        fault,
   output logic [31:0] fault_addr,
   input  logic        fault_clr,
   output logic        p_req,
   output logic        p_we,
   output logic [31:0] p_addr,
   output logic [31:0] p_wdata,
   output logic [3:0]  p_be,
   input  logic [31:0] p_rdata,
   input  logic        p_ack
);

   localparam int GAW = $clog2(GLOBAL_WORDS);
   localparam int SAW = $clog2(STACK_WORDS);
   localparam int CW  = $clog2(PERI_TIMEOUT + 1);

   localparam logic [31:0] GLOBAL_LIM = GLOBAL_BASE + 32'(4 * GLOBAL_WORDS);
   localparam logic [31:0] STACK_BASE = STACK_TOP + 32'd4 - 32'(4 * STACK_WORDS);
   localparam logic [31:0] STACK_LIM  = STACK_TOP + 32'd3;
   localparam logic [31:0] PERI_LIM   = PERI_BASE + PERI_SPAN;
   localparam logic [CW-1:0] CNT_LAST = CW'(PERI_TIMEOUT - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PERI = 1'b1
   } state_t;

   // Registered state
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;
   logic [31:0]   fault_addr_q, fault_addr_d;
   logic          p_req_q, p_req_d;
   logic          p_we_q, p_we_d;
   logic [31:0]   p_addr_q, p_addr_d;
   logic [31:0]   p_wdata_q, p_wdata_d;
   logic [3:0]    p_be_q, p_be_d;
   // Peripheral request context, needed to extend the response and to report a timeout
   logic [1:0]    sz_q, sz_d;
   logic          uns_q, uns_d;
   logic [1:0]    lane_q, lane_d;
   logic [31:0]   addr_q, addr_d;

   // Storage
   logic [31:0] global_mem [GLOBAL_WORDS];
   logic [31:0] stack_mem  [STACK_WORDS];

   // Decode of the incoming request
   logic           hit_g, hit_s, hit_p, misalign, bad;
   logic [1:0]     lane;
   logic [GAW-1:0] g_idx;
   logic [SAW-1:0] s_idx;
   logic [31:0]    wsh;
   logic [3:0]     be;
   logic           g_we, s_we;
   logic [31:0]    err_addr;

   // Shift the addressed lane down to bit 0 and sign/zero extend it
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [1:0] ln, input logic uns);
      logic [31:0] sh;
      sh = word >> {ln, 3'b000};
      case (sz)
         2'd0:    return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   // Address decode, alignment check, store lane shifting and byte enables
   always_comb begin
      lane     = addr[1:0];
      hit_g    = (addr >= GLOBAL_BASE) && (addr < GLOBAL_LIM);
      hit_s    = (addr >= STACK_BASE) && (addr <= STACK_LIM);
      hit_p    = (addr >= PERI_BASE) && (addr < PERI_LIM);
      misalign = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
      bad      = (size == 2'd3) || misalign || !(hit_g || hit_s || hit_p);
      g_idx    = GAW'((addr - GLOBAL_BASE) >> 2);
      s_idx    = SAW'((addr - STACK_BASE) >> 2);
      case (size)
         2'd0:    begin wsh = {24'h0, wdata[7:0]}  << {lane, 3'b000}; be = 4'b0001 << lane; end
         2'd1:    begin wsh = {16'h0, wdata[15:0]} << {lane, 3'b000}; be = 4'b0011 << lane; end
         default: begin wsh = wdata;                                  be = 4'b1111;         end
      endcase
   end

   // Next-state, completion and peripheral request logic
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred on any path.
      state_d      = state_q;
      cnt_d        = cnt_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      busy_d       = busy_q;
      rdata_d      = rdata_q;
      p_req_d      = p_req_q;
      p_we_d       = p_we_q;
      p_addr_d     = p_addr_q;
      p_wdata_d    = p_wdata_q;
      p_be_d       = p_be_q;
      sz_d         = sz_q;
      uns_d        = uns_q;
      lane_d       = lane_q;
      addr_d       = addr_q;
      g_we         = 1'b0;
      s_we         = 1'b0;
      err_addr     = addr;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (req) begin
               if (bad) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
                  if (!we) rdata_d = ERR_DATA;
               end else if (hit_p) begin
                  state_d   = S_PERI;
                  cnt_d     = '0;
                  busy_d    = 1'b1;
                  p_req_d   = 1'b1;
                  p_we_d    = we;
                  p_addr_d  = {addr[31:2], 2'b00};
                  p_be_d    = be;
                  p_wdata_d = wsh;
                  sz_d      = size;
                  uns_d     = unsgn;
                  lane_d    = lane;
                  addr_d    = addr;
               end else begin
                  done_d = 1'b1;
                  if (hit_g) begin
                     g_we = we;
                     if (!we) rdata_d = load_ext(global_mem[g_idx], size, lane, unsgn);
                  end else begin
                     s_we = we;
                     if (!we) rdata_d = load_ext(stack_mem[s_idx], size, lane, unsgn);
                  end
               end
            end
         end
         S_PERI: begin
            // An ack in the final counted cycle still wins over the timeout
            if (p_ack) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               p_req_d = 1'b0;
               if (!p_we_q) rdata_d = load_ext(p_rdata, sz_q, lane_q, uns_q);
            end else if (cnt_q == CNT_LAST) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               err_d    = 1'b1;
               busy_d   = 1'b0;
               p_req_d  = 1'b0;
               err_addr = addr_q;
               if (!p_we_q) rdata_d = ERR_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sticky fault capture: first faulting address is kept; a coincident clear loses to a new fault
   always_comb begin
      fault_d      = fault_clr ? 1'b0 : fault_q;
      fault_addr_d = fault_clr ? 32'h0 : fault_addr_q;
      if (done_d && err_d) begin
         fault_d = 1'b1;
         if (!fault_q || fault_clr) fault_addr_d = err_addr;
      end
   end

   // Control and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         rdata_q      <= 32'h0;
         fault_q      <= 1'b0;
         fault_addr_q <= 32'h0;
         p_req_q      <= 1'b0;
         p_we_q       <= 1'b0;
         p_addr_q     <= 32'h0;
         p_wdata_q    <= 32'h0;
         p_be_q       <= 4'h0;
         sz_q         <= 2'd0;
         uns_q        <= 1'b0;
         lane_q       <= 2'd0;
         addr_q       <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         done_q       <= done_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         rdata_q      <= rdata_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         p_req_q      <= p_req_d;
         p_we_q       <= p_we_d;
         p_addr_q     <= p_addr_d;
         p_wdata_q    <= p_wdata_d;
         p_be_q       <= p_be_d;
         sz_q         <= sz_d;
         uns_q        <= uns_d;
         lane_q       <= lane_d;
         addr_q       <= addr_d;
      end
   end

   // Byte-enabled writes into the global and stack arrays
   always_ff @(posedge clk) begin
      // NOTE: the arrays have no reset; contents stay undefined until written and survive reset_n.
      for (int b = 0; b < 4; b++) begin
         if (g_we && be[b]) global_mem[g_idx][8*b +: 8] <= wsh[8*b +: 8];
         if (s_we && be[b]) stack_mem[s_idx][8*b +: 8]  <= wsh[8*b +: 8];
      end
   end

   assign rdata      = rdata_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;
   assign p_req      = p_req_q;
   assign p_we       = p_we_q;
   assign p_addr     = p_addr_q;
   assign p_wdata    = p_wdata_q;
   assign p_be       = p_be_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench for data_mem_ctrl.
// Reference model: byte-addressed associative memory, range arithmetic for
// decode, and a simple sticky-fault model.
module tb_data_mem_ctrl;

   localparam int          PT   = 16;
   localparam logic [31:0] ERRD = 32'hCCCC_CCCC;
   localparam logic [63:0] G_LO = 64'h1001_0000;
   localparam logic [63:0] G_HI = G_LO + 64'd128;
   localparam logic [63:0] S_HI = 64'h7FFF_FFFC + 64'd3;
   localparam logic [63:0] S_LO = 64'h7FFF_FFFC + 64'd4 - 64'd128;
   localparam logic [63:0] P_LO = 64'h4000_0000;
   localparam logic [63:0] P_HI = P_LO + 64'h1000;
   localparam int R_NONE = 0, R_GLB = 1, R_STK = 2, R_PERI = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, unsgn = 1'b0, fault_clr = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [31:0] addr = 32'h0, wdata = 32'h0, p_rdata = 32'h0;
   logic        p_ack = 1'b0;
   logic [31:0] rdata, fault_addr, p_addr, p_wdata;
   logic        done, err, busy, fault, p_req, p_we;
   logic [3:0]  p_be;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0]  mem_m [logic [31:0]];
   logic        fault_m = 1'b0;
   logic [31:0] fault_addr_m = 32'h0;
   logic [31:0] exp_rdata = 32'h0;

   data_mem_ctrl dut (
      .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size), .unsgn(unsgn),
      .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
      .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be),
      .p_rdata(p_rdata), .p_ack(p_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int region(input logic [31:0] a);
      logic [63:0] x;
      x = {32'h0, a};
      if (x >= G_LO && x < G_HI)  return R_GLB;
      if (x >= S_LO && x <= S_HI) return R_STK;
      if (x >= P_LO && x < P_HI)  return R_PERI;
      return R_NONE;
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] v, input int n, input logic u);
      logic [31:0] msk, r;
      msk = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      r   = v & msk;
      if (!u && n < 4 && r[8*n-1]) r = r | ~msk;
      return r;
   endfunction

   function automatic logic [31:0] mem_load(input logic [31:0] a, input int n);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + 32'(i)]) << (8 * i));
      return v;
   endfunction

   task automatic mem_store(input logic [31:0] a, input int n, input logic [31:0] wd);
      for (int i = 0; i < n; i++) mem_m[a + 32'(i)] = 8'(wd >> (8 * i));
   endtask

   task automatic model_err(input logic [31:0] a);
      if (!fault_m) fault_addr_m = a;
      fault_m = 1'b1;
   endtask

   task automatic check_fault(input string tag);
      check({tag, "_fault"}, {31'h0, fault}, {31'h0, fault_m});
      check({tag, "_fault_addr"}, fault_addr, fault_addr_m);
   endtask

   // One access, entered and left at 1 time unit after a rising edge
   task automatic access(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic clr,
                         input int ack_dly, input logic [31:0] prd, input logic noise);
      int          n, kind, k, lane;
      logic        bad, ok;
      logic [31:0] v, epw;
      logic [3:0]  ebe;
      n    = 1 << sz;
      lane = int'(a[1:0]);
      kind = region(a);
      bad  = (sz == 2'd3) || ((int'(a[2:0]) % n) != 0) || (kind == R_NONE);
      req = 1'b1; we = w; size = sz; unsgn = u; addr = a; wdata = wd; fault_clr = clr;
      @(posedge clk); #1;
      req = 1'b0; fault_clr = 1'b0;
      if (clr) begin fault_m = 1'b0; fault_addr_m = 32'h0; end
      if (bad) begin
         if (!w) exp_rdata = ERRD;
         model_err(a);
         check("bad_done", {31'h0, done}, 32'd1);
         check("bad_err", {31'h0, err}, 32'd1);
         check("bad_busy", {31'h0, busy}, 32'd0);
      end else if (kind != R_PERI) begin
         if (w) mem_store(a, n, wd);
         else   exp_rdata = ext(mem_load(a, n), n, u);
         check("mem_done", {31'h0, done}, 32'd1);
         check("mem_err", {31'h0, err}, 32'd0);
         check("mem_busy", {31'h0, busy}, 32'd0);
      end else begin
         ebe = 4'h0; epw = 32'h0; v = 32'h0;
         for (int i = 0; i < n; i++) begin
            ebe[lane + i] = 1'b1;
            epw = epw | (((wd >> (8 * i)) & 32'hFF) << (8 * (lane + i)));
            v   = v | (((prd >> (8 * (lane + i))) & 32'hFF) << (8 * i));
         end
         check("p_addr", p_addr, a & 32'hFFFF_FFFC);
         check("p_be", {28'h0, p_be}, {28'h0, ebe});
         check("p_we", {31'h0, p_we}, {31'h0, w});
         if (w) check("p_wdata", p_wdata, epw);
         ok = (ack_dly >= 1) && (ack_dly <= PT);
         for (k = 1; k <= PT; k++) begin
            check("peri_busy", {31'h0, busy}, 32'd1);
            check("peri_p_req", {31'h0, p_req}, 32'd1);
            check("peri_no_done", {31'h0, done}, 32'd0);
            if (noise) begin req = 1'b1; we = 1'b0; size = 2'd0; addr = 32'h0; end
            if (k == ack_dly) begin p_ack = 1'b1; p_rdata = prd; end
            @(posedge clk); #1;
            p_ack = 1'b0; p_rdata = $urandom;
            if (k == ack_dly || k == PT) break;
         end
         req = 1'b0;
         if (!w) exp_rdata = ok ? ext(v, n, u) : ERRD;
         if (!ok) model_err(a);
         check("peri_done", {31'h0, done}, 32'd1);
         check("peri_err", {31'h0, err}, {31'h0, !ok});
         check("peri_busy_end", {31'h0, busy}, 32'd0);
         check("peri_p_req_end", {31'h0, p_req}, 32'd0);
      end
      check("rdata", rdata, exp_rdata);
      check_fault("acc");
   endtask

   task automatic clear_fault();
      fault_clr = 1'b1;
      @(posedge clk); #1;
      fault_clr = 1'b0;
      fault_m = 1'b0; fault_addr_m = 32'h0;
      check("clr_done", {31'h0, done}, 32'd0);
      check_fault("clr");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] unm [8];
      logic [31:0] a, msk;
      logic [1:0]  sz;
      int          sel;

      // Reset state, checked while reset is held
      #3;
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_err", {31'h0, err}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_fault", {31'h0, fault}, 32'd0);
      check("rst_p_req", {31'h0, p_req}, 32'd0);
      check("rst_p_we", {31'h0, p_we}, 32'd0);
      check("rst_p_be", {28'h0, p_be}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_fault_addr", fault_addr, 32'h0);
      check("rst_p_addr", p_addr, 32'h0);
      check("rst_p_wdata", p_wdata, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Initialise every mapped memory word so the model never reads unknown data
      for (int i = 0; i < 32; i++) access(1'b1, 2'd2, 1'b0, 32'(G_LO) + 32'(4 * i), $urandom, 1'b0, 0, 32'h0, 1'b0);
      for (int i = 0; i < 32; i++) access(1'b1, 2'd2, 1'b0, 32'(S_LO) + 32'(4 * i), $urandom, 1'b0, 0, 32'h0, 1'b0);

      // Word store then signed byte load
      access(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 1'b0);
      access(1'b0, 2'd0, 1'b0, 32'h1001_0005, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      check("tp1_rdata", rdata, 32'hFFFF_FFBE);

      // Halfword store at top of stack, word readback, misaligned half load
      access(1'b1, 2'd1, 1'b0, 32'h7FFF_FFFE, 32'h0000_1234, 1'b0, 0, 32'h0, 1'b0);
      access(1'b0, 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      check("tp2_upper", {16'h0, rdata[31:16]}, 32'h0000_1234);
      access(1'b0, 2'd1, 1'b0, 32'h7FFF_FFFD, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      check("tp2_fault_addr", fault_addr, 32'h7FFF_FFFD);
      clear_fault();

      // Peripheral word load acked in its third cycle; req noise while busy is ignored
      access(1'b0, 2'd2, 1'b0, 32'h4000_0010, 32'h0, 1'b0, 3, 32'h0000_0055, 1'b1);
      check("tp3_rdata", rdata, 32'h0000_0055);
      // Ack exactly in the timeout cycle still succeeds
      access(1'b0, 2'd0, 1'b1, 32'h4000_0023, 32'h0, 1'b0, PT, 32'hA1B2_C3D4, 1'b0);
      check("ack_at_timeout_rdata", rdata, 32'h0000_00A1);
      // No ack: timeout
      access(1'b0, 2'd2, 1'b0, 32'h4000_0020, 32'h0, 1'b0, PT + 5, 32'h0, 1'b0);
      check("tp4_rdata", rdata, 32'hCCCC_CCCC);
      check("tp4_fault", {31'h0, fault}, 32'd1);
      clear_fault();

      // First fault kept; clear coincident with a new fault lets the new one win
      access(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      access(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      check("tp5_keep_first", fault_addr, 32'h0000_0100);
      access(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0, 1'b1, 0, 32'h0, 1'b0);
      check("tp5_new_wins", fault_addr, 32'h0000_000C);

      // Reset in the middle of a peripheral transaction
      req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h4000_0100;
      @(posedge clk); #1;
      req = 1'b0;
      check("rst_peri_busy_before", {31'h0, busy}, 32'd1);
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("rst_peri_p_req", {31'h0, p_req}, 32'd0);
      check("rst_peri_busy", {31'h0, busy}, 32'd0);
      check("rst_peri_done", {31'h0, done}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      fault_m = 1'b0; fault_addr_m = 32'h0; exp_rdata = 32'h0;
      @(posedge clk); #1;
      check("post_rst_done", {31'h0, done}, 32'd0);
      check_fault("post_rst");
      access(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      check("post_rst_mem", rdata, 32'hDEAD_BEEF);

      // Randomized traffic across all regions and boundaries
      unm[0] = 32'(G_LO) - 32'd1;  unm[1] = 32'(G_HI);
      unm[2] = 32'(S_LO) - 32'd1;  unm[3] = 32'h8000_0000;
      unm[4] = 32'(P_LO) - 32'd1;  unm[5] = 32'(P_HI);
      unm[6] = 32'h0000_0100;      unm[7] = 32'hFFFF_FFFC;
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 7));
         sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case (sel)
            0, 1, 2: a = 32'(G_LO) + 32'($urandom_range(0, 127));
            3, 4:    a = 32'(S_LO) + 32'($urandom_range(0, 127));
            5, 6:    a = 32'(P_LO) + 32'($urandom_range(0, 4095));
            default: a = unm[$urandom_range(0, 7)];
         endcase
         if (sz != 2'd3 && $urandom_range(0, 3) != 0) begin
            msk = ~((32'd1 << sz) - 32'd1);
            a   = a & msk;
         end
         access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                ($urandom_range(0, 9) == 0), int'($urandom_range(1, PT + 3)), $urandom,
                1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
